// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration chain loader and the fabric top level.
// Holds the loader state encoding, default geometry and the per-word bit budget helper.
package cfg_loader_pkg;

  localparam int DEF_WORD_W    = 8;
  localparam int DEF_CHAIN_LEN = 1024;
  localparam int DEF_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } load_state_e;

  // Bits of the next word that still fit; the tail word may be truncated.
  function automatic int word_bits(input int chain_len, input int loaded, input int word_w);
    int left;
    left = chain_len - loaded;
    return (left < word_w) ? left : word_w;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Loads one bitstream word and streams its upper load_bits bits MSB-first onto the
// chain head, with a registered shift enable aligned to each head bit.
module cfg_word_serializer
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int BW     = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [BW-1:0]     load_bits,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              last_bit
);

  logic [WORD_W-1:0] shreg_reg;
  logic [BW-1:0]     left_reg;
  logic              head_reg;
  logic              shift_en_reg;

  // The MSB goes out on the load edge itself so the first bit appears one cycle after the handshake.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      shreg_reg    <= '0;
      left_reg     <= '0;
      head_reg     <= 1'b0;
      shift_en_reg <= 1'b0;
    end else if (load) begin
      head_reg     <= load_data[WORD_W-1];
      shift_en_reg <= 1'b1;
      shreg_reg    <= load_data << 1;
      left_reg     <= load_bits - BW'(1);
    end else if (left_reg != '0) begin
      head_reg     <= shreg_reg[WORD_W-1];
      shift_en_reg <= 1'b1;
      shreg_reg    <= shreg_reg << 1;
      left_reg     <= left_reg - BW'(1);
    end else begin
      shift_en_reg <= 1'b0;
    end
  end

  assign ccff_head     = head_reg;
  assign ccff_shift_en = shift_en_reg;
  assign last_bit      = shift_en_reg && (left_reg == '0);

endmodule

// File: rtl/config_chain_loader.sv
// Configuration chain loader: fetches bitstream words over valid/ready, serializes
// exactly CHAIN_LEN bits into the CCFF chain and tracks timeout and both parities.
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count,
  output logic              new_parity,
  output logic              old_parity
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  load_state_e      state_reg;
  logic [TW-1:0]    tmo_reg;
  logic [CNT_W-1:0] bit_count_reg;
  logic             cfg_ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             error_reg;
  logic             new_parity_reg;
  logic             old_parity_reg;

  logic             handshake;
  logic             last_bit;
  logic [BW-1:0]    bits_this_word;

  assign handshake      = cfg_valid && cfg_ready_reg;
  assign bits_this_word = BW'(word_bits(CHAIN_LEN, int'(bit_count_reg), WORD_W));

  cfg_word_serializer #(
    .WORD_W (WORD_W),
    .BW     (BW)
  ) u_serializer (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .load          (handshake),
    .load_data     (cfg_data),
    .load_bits     (bits_this_word),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .last_bit      (last_bit)
  );

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_reg      <= IDLE;
      tmo_reg        <= '0;
      bit_count_reg  <= '0;
      cfg_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      new_parity_reg <= 1'b0;
      old_parity_reg <= 1'b0;
    end else begin
      // Shift enable is only ever high in SHIFT, so this never collides with the start clears.
      if (ccff_shift_en) begin
        bit_count_reg  <= bit_count_reg + CNT_W'(1);
        new_parity_reg <= new_parity_reg ^ ccff_head;
        old_parity_reg <= old_parity_reg ^ ccff_tail;
      end
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_reg      <= FETCH;
            cfg_ready_reg  <= 1'b1;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            tmo_reg        <= '0;
            bit_count_reg  <= '0;
            new_parity_reg <= 1'b0;
            old_parity_reg <= 1'b0;
          end
        end
        FETCH: begin
          if (handshake) begin
            state_reg     <= SHIFT;
            cfg_ready_reg <= 1'b0;
            tmo_reg       <= '0;
          end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
            state_reg     <= ERR;
            cfg_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            error_reg     <= 1'b1;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (bit_count_reg == CNT_W'(CHAIN_LEN - 1)) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg     <= FETCH;
              cfg_ready_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          cfg_ready_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = cfg_ready_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign bit_count  = bit_count_reg;
  assign new_parity = new_parity_reg;
  assign old_parity = old_parity_reg;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 20-bit chain instance (TIMEOUT=4) with a chain model
// and a 16-bit instance; head bits are checked against a per-instance scoreboard queue.
module tb_config_chain_loader;

  localparam int WW  = 8;
  localparam int LA  = 20;
  localparam int LB  = 16;
  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          a_start, a_valid, a_ready, a_head, a_shift_en, a_tail;
  logic          a_busy, a_done, a_error, a_new_par, a_old_par;
  logic [WW-1:0] a_data;
  logic [4:0]    a_count;

  logic          b_start, b_valid, b_ready, b_head, b_shift_en, b_tail;
  logic          b_busy, b_done, b_error, b_new_par, b_old_par;
  logic [WW-1:0] b_data;
  logic [4:0]    b_count;

  config_chain_loader #(.WORD_W(WW), .CHAIN_LEN(LA), .TIMEOUT(TMO)) dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(a_start), .cfg_data(a_data),
    .cfg_valid(a_valid), .cfg_ready(a_ready), .ccff_head(a_head), .ccff_shift_en(a_shift_en),
    .ccff_tail(a_tail), .busy(a_busy), .done(a_done), .error(a_error),
    .bit_count(a_count), .new_parity(a_new_par), .old_parity(a_old_par)
  );

  config_chain_loader #(.WORD_W(WW), .CHAIN_LEN(LB), .TIMEOUT(TMO)) dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(b_start), .cfg_data(b_data),
    .cfg_valid(b_valid), .cfg_ready(b_ready), .ccff_head(b_head), .ccff_shift_en(b_shift_en),
    .ccff_tail(b_tail), .busy(b_busy), .done(b_done), .error(b_error),
    .bit_count(b_count), .new_parity(b_new_par), .old_parity(b_old_par)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model for instance A: head enters at bit 0, tail is bit LA-1.
  logic [LA-1:0] a_chain;
  logic [LA-1:0] preload_val;
  logic          preload_req;
  always @(posedge clk) begin
    if (preload_req) a_chain <= preload_val;
    else if (a_shift_en === 1'b1) a_chain <= {a_chain[LA-2:0], a_head};
  end
  assign a_tail = a_chain[LA-1];
  assign b_tail = 1'b0;

  logic a_q[$];
  logic b_q[$];
  int   a_pushed, b_pushed, a_shifts, b_shifts, a_first, a_last, b_last, a_done_cyc, b_done_cyc;
  logic a_new_exp, a_old_exp, b_new_exp, a_e, b_e;

  always @(negedge clk) begin
    if (a_shift_en === 1'b1) begin
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_shift: shift_en got 1 at cycle %0d, required 0", cyc);
      end else begin
        a_e = a_q.pop_front();
        checks++;
        if (a_head !== a_e) begin
          errors++;
          $display("FAIL a_head shift %0d: got %b, required %b", a_shifts, a_head, a_e);
        end else
          $display("a: shift %0d head=%b ok", a_shifts, a_head);
      end
      if (a_shifts == 0) a_first = cyc;
      a_last = cyc;
      a_shifts++;
    end
  end

  always @(negedge clk) begin
    if (b_shift_en === 1'b1) begin
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_shift: shift_en got 1 at cycle %0d, required 0", cyc);
      end else begin
        b_e = b_q.pop_front();
        checks++;
        if (b_head !== b_e) begin
          errors++;
          $display("FAIL b_head shift %0d: got %b, required %b", b_shifts, b_head, b_e);
        end else
          $display("b: shift %0d head=%b ok", b_shifts, b_head);
      end
      b_last = cyc;
      b_shifts++;
    end
  end

  task automatic a_begin_load(input logic [LA-1:0] pre);
    preload_val = pre;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    a_q.delete();
    a_pushed  = 0;
    a_shifts  = 0;
    a_new_exp = 1'b0;
    a_old_exp = ^pre;
    a_start   = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_drive_word(input logic [WW-1:0] w);
    int k;
    int nb;
    a_data  = w;
    a_valid = 1'b1;
    k = 0;
    while (a_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_ready_wait: cfg_ready got %b after %0d cycles, required 1", a_ready, k);
    end else begin
      nb = (LA - a_pushed < WW) ? LA - a_pushed : WW;
      for (int i = 0; i < nb; i++) begin
        a_q.push_back(w[WW-1-i]);
        a_new_exp ^= w[WW-1-i];
      end
      a_pushed += nb;
      $display("a: word %h accepted, %0d bits queued", w, nb);
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_data  = WW'($urandom);
  endtask

  task automatic b_drive_word(input logic [WW-1:0] w);
    int k;
    int nb;
    b_data  = w;
    b_valid = 1'b1;
    k = 0;
    while (b_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_ready_wait: cfg_ready got %b after %0d cycles, required 1", b_ready, k);
    end else begin
      nb = (LB - b_pushed < WW) ? LB - b_pushed : WW;
      for (int i = 0; i < nb; i++) begin
        b_q.push_back(w[WW-1-i]);
        b_new_exp ^= w[WW-1-i];
      end
      b_pushed += nb;
      $display("b: word %h accepted, %0d bits queued", w, nb);
    end
    @(negedge clk);
    b_valid = 1'b0;
    b_data  = WW'($urandom);
  endtask

  task automatic a_wait_done();
    int k;
    k = 0;
    while (a_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    a_done_cyc = cyc;
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL a_done_wait: done got %b after %0d cycles, required 1", a_done, k);
    end
  endtask

  task automatic a_load_three();
    a_drive_word(8'hA5);
    a_drive_word(8'h3C);
    a_drive_word(8'hF0);
    a_wait_done();
  endtask

  task automatic a_check_result(input string tag, input logic [LA-1:0] exp_chain);
    checks += 9;
    if (a_busy !== 1'b0 || a_error !== 1'b0) begin
      errors++; $display("FAIL %s busy/error: got %b/%b, required 0/0", tag, a_busy, a_error);
    end
    if (a_count !== 5'(LA)) begin
      errors++; $display("FAIL %s bit_count: got %0d, required %0d", tag, a_count, LA);
    end
    if (a_new_par !== a_new_exp) begin
      errors++; $display("FAIL %s new_parity: got %b, required %b", tag, a_new_par, a_new_exp);
    end
    if (a_old_par !== a_old_exp) begin
      errors++; $display("FAIL %s old_parity: got %b, required %b", tag, a_old_par, a_old_exp);
    end
    if (a_chain !== exp_chain) begin
      errors++; $display("FAIL %s chain: got %h, required %h", tag, a_chain, exp_chain);
    end
    if (a_q.size() != 0) begin
      errors++; $display("FAIL %s leftover: got %0d unshifted bits, required 0", tag, a_q.size());
    end
    if (a_shifts != LA) begin
      errors++; $display("FAIL %s shift_count: got %0d, required %0d", tag, a_shifts, LA);
    end
    if (a_last - a_first + 1 != LA + 2) begin
      errors++; $display("FAIL %s shift_span: got %0d cycles, required %0d", tag, a_last - a_first + 1, LA + 2);
    end
    if (a_done_cyc != a_last + 1) begin
      errors++; $display("FAIL %s done_timing: got cycle %0d, required %0d", tag, a_done_cyc, a_last + 1);
    end
    $display("%s: count=%0d new_par=%b old_par=%b chain=%h", tag, a_count, a_new_par, a_old_par, a_chain);
  endtask

  task automatic check_all_zero(input string tag);
    checks += 2;
    if ({a_ready, a_head, a_shift_en, a_busy, a_done, a_error, a_new_par, a_old_par, a_count} !== '0) begin
      errors++;
      $display("FAIL %s a_outputs: got r%b h%b s%b b%b d%b e%b np%b op%b cnt%0d, required all 0", tag,
               a_ready, a_head, a_shift_en, a_busy, a_done, a_error, a_new_par, a_old_par, a_count);
    end
    if ({b_ready, b_head, b_shift_en, b_busy, b_done, b_error, b_new_par, b_old_par, b_count} !== '0) begin
      errors++;
      $display("FAIL %s b_outputs: got r%b h%b s%b b%b d%b e%b np%b op%b cnt%0d, required all 0", tag,
               b_ready, b_head, b_shift_en, b_busy, b_done, b_error, b_new_par, b_old_par, b_count);
    end
    $display("%s: outputs after reset checked", tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    preload_val = '1;
    preload_req = 1'b1;
    repeat (3) @(negedge clk);
    preload_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
  endtask

  task automatic test_idle_valid();
    a_valid = 1'b1;
    a_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid cycle %0d: ready/busy got %b/%b, required 0/0", i, a_ready, a_busy);
      end else
        $display("idle_valid: cycle %0d ready=0 busy=0", i);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_full_load();
    a_begin_load('1);
    a_load_three();
    a_check_result("full_load", 20'hA53CF);
  endtask

  task automatic test_ignored_inputs();
    a_valid = 1'b1;
    a_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || a_done !== 1'b1 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL done_valid cycle %0d: ready/done/busy got %b/%b/%b, required 0/1/0", i, a_ready, a_done, a_busy);
      end else
        $display("done_valid: cycle %0d held in DONE", i);
    end
    a_valid = 1'b0;
    a_begin_load('1);
    a_drive_word(8'hA5);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_error !== 1'b0 || a_shift_en !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: busy/error/shift_en got %b/%b/%b, required 1/0/1", a_busy, a_error, a_shift_en);
    end
    a_drive_word(8'h3C);
    a_drive_word(8'hF0);
    a_wait_done();
    a_check_result("busy_start", 20'hA53CF);
  endtask

  task automatic test_starvation();
    int k;
    a_begin_load('1);
    a_drive_word(8'hA5);
    k = 0;
    while (a_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int n = 0; n < TMO; n++) begin
      checks++;
      if (a_error !== 1'b0 || a_ready !== 1'b1) begin
        errors++;
        $display("FAIL starve_wait cycle %0d: error/ready got %b/%b, required 0/1", n, a_error, a_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (a_error !== 1'b1 || a_ready !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_count !== 5'd8) begin
      errors++;
      $display("FAIL starve_err: error/ready/busy/done/count got %b/%b/%b/%b/%0d, required 1/0/0/0/8",
               a_error, a_ready, a_busy, a_done, a_count);
    end else
      $display("starve: error after %0d idle FETCH cycles, count=%0d", TMO, a_count);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_shift_en !== 1'b0 || a_error !== 1'b1) begin
        errors++;
        $display("FAIL starve_hold cycle %0d: shift_en/error got %b/%b, required 0/1", i, a_shift_en, a_error);
      end
    end
    a_begin_load('1);
    a_load_three();
    a_check_result("starve_reload", 20'hA53CF);
  endtask

  task automatic test_reset_mid_shift();
    a_begin_load('1);
    a_drive_word(8'hA5);
    a_drive_word(8'h3C);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    a_q.delete();
    check_all_zero("mid_reset");
    rst_n   = 1'b1;
    a_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: ready/busy got %b/%b, required 0/0", a_ready, a_busy);
    end
    a_valid = 1'b0;
    a_begin_load(20'h00001);
    a_load_three();
    a_check_result("after_reset", 20'hA53CF);
  endtask

  task automatic test_chain16();
    int k;
    b_q.delete();
    b_pushed  = 0;
    b_shifts  = 0;
    b_new_exp = 1'b0;
    b_start   = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_drive_word(8'hFF);
    b_drive_word(8'h01);
    k = 0;
    while (b_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    b_done_cyc = cyc;
    checks += 5;
    if (b_done !== 1'b1 || b_error !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL c16 status: done/error/busy got %b/%b/%b, required 1/0/0", b_done, b_error, b_busy);
    end
    if (b_count !== 5'(LB) || b_shifts != LB || b_q.size() != 0) begin
      errors++; $display("FAIL c16 count: got count=%0d shifts=%0d left=%0d, required %0d/%0d/0",
                         b_count, b_shifts, b_q.size(), LB, LB);
    end
    if (b_new_par !== b_new_exp) begin
      errors++; $display("FAIL c16 new_parity: got %b, required %b", b_new_par, b_new_exp);
    end
    if (b_old_par !== 1'b0) begin
      errors++; $display("FAIL c16 old_parity: got %b, required 0", b_old_par);
    end
    if (b_done_cyc != b_last + 1) begin
      errors++; $display("FAIL c16 done_timing: got cycle %0d, required %0d", b_done_cyc, b_last + 1);
    end
    $display("c16: count=%0d new_par=%b done=%b", b_count, b_new_par, b_done);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    preload_req = 1'b0; preload_val = '1;
    a_pushed = 0; b_pushed = 0; a_shifts = 0; b_shifts = 0;
    a_first = 0; a_last = 0; b_last = 0; a_done_cyc = 0; b_done_cyc = 0;
    a_new_exp = 1'b0; a_old_exp = 1'b0; b_new_exp = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_valid();
    test_full_load();
    test_ignored_inputs();
    test_starvation();
    test_reset_mid_shift();
    test_chain16();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got past 200000 time units, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
